// File: rtl/otp_pad_store_if.sv
// ----------------------------------------------------------------------------
// otp_pad_store_if
// Bus bundle for the single-use pad store. It carries the write handshake
// (pad capture from the generator) and the fetch channel (pad lookup by index
// from the decrypt path).
//
//   wr_valid / wr_data   : pad byte offered for storage
//   wr_ready / wr_index  : slot free and store running / slot the pad lands in
//   rd_req / rd_index    : one-cycle fetch request and slot to fetch
//   rd_valid             : one-cycle pulse, fetch result available
//   rd_data / rd_err     : fetched pad (0 on error) / miss or scrub-time fetch
//
// Modports: master = pad producer / consumer side, slave = the store.
// ----------------------------------------------------------------------------
interface otp_pad_store_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] wr_index;
    logic          rd_req;
    logic [AW-1:0] rd_index;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;

    modport master (
        output wr_valid, wr_data, rd_req, rd_index,
        input  wr_ready, wr_index, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  wr_valid, wr_data, rd_req, rd_index,
        output wr_ready, wr_index, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/otp_pad_store.sv
// ----------------------------------------------------------------------------
// otp_pad_store
// Single-use pad buffer between the LFSR pad generator and the OTP decrypt
// path. Each pad written is stored at the current write pointer, and that slot
// number is returned as the index. A fetch by index returns the pad once and
// then burns the slot (data zeroed, live flag cleared). After reset a scrub
// sequence zeroes every slot, one per cycle, before traffic is accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          otp_pad_store_if.slave (write handshake + fetch channel)
//   o_live_cnt   number of unconsumed pads, 0..2**AW
//   o_busy       high while scrubbing
//   o_err_cnt    saturating fetch-error count
//
// Optional feature: define OTP_STORE_STATS_EN to build the fetch-error
// counter; otherwise o_err_cnt is tied to zero.
// ----------------------------------------------------------------------------
module otp_pad_store #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    otp_pad_store_if.slave       bus,
    output logic [AW:0]          o_live_cnt,
    output logic                 o_busy,
    output logic [7:0]           o_err_cnt
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    typedef enum logic {S_SCRUB, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_sp;
    logic [AW-1:0]   r_wp;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW:0]     r_live_cnt;
    logic            r_rd_valid;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_err;

    logic            w_run;
    logic            w_wr_ready;
    logic            w_wr_fire;
    logic            w_rd_hit;

    assign w_run      = (r_state == S_RUN);
    // The store never overwrites: it stalls on the oldest unburned slot even
    // when other slots are free, so indices stay in issue order.
    assign w_wr_ready = w_run && !r_live[r_wp];
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;
    // A hit and a write can never target the same slot (hit needs live=1,
    // write needs live=0), so a fetch of wp during its write sees a miss.
    assign w_rd_hit   = bus.rd_req && w_run && r_live[bus.rd_index];

    assign bus.wr_ready = w_wr_ready;
    assign bus.wr_index = r_wp;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_err   = r_rd_err;
    assign o_live_cnt   = r_live_cnt;
    assign o_busy       = !w_run;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_SCRUB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the block leaves
        // w_state_next unassigned (that would infer a latch).
        w_state_next = r_state;
        case (r_state)
            S_SCRUB: if (r_sp == IDX_LAST) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_SCRUB;
        endcase
    end

    // -------------------------------------------------------- control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp       <= '0;
            r_wp       <= '0;
            r_live     <= '0;
            r_live_cnt <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            if (!w_run) begin
                r_live[r_sp] <= 1'b0;
                r_sp         <= r_sp + IDX_ONE;
            end
            if (w_wr_fire) begin
                r_live[r_wp] <= 1'b1;
                r_wp         <= r_wp + IDX_ONE;
            end
            if (w_rd_hit) begin
                r_live[bus.rd_index] <= 1'b0;
            end

            case ({w_wr_fire, w_rd_hit})
                2'b10:   r_live_cnt <= r_live_cnt + CNT_ONE;
                2'b01:   r_live_cnt <= r_live_cnt - CNT_ONE;
                default: r_live_cnt <= r_live_cnt;
            endcase

            // Result registers hold between fetches; only rd_valid pulses.
            r_rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                if (w_rd_hit) begin
                    r_rd_data <= r_mem[bus.rd_index];
                    r_rd_err  <= 1'b0;
                end else begin
                    r_rd_data <= '0;
                    r_rd_err  <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------- storage
    // NOTE: the pad array has no reset branch; the scrub sequence zeroes it
    // after every reset, and live flags gate every read in the meantime.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_sp] <= '0;
        end
        if (w_wr_fire) begin
            r_mem[r_wp] <= bus.wr_data;
        end
        if (w_rd_hit) begin
            r_mem[bus.rd_index] <= '0;
        end
    end

    // ----------------------------------------------------- error statistics
`ifdef OTP_STORE_STATS_EN
    logic [7:0] r_err_cnt;

    // Counts in the same edge that raises rd_valid with rd_err set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= 8'h00;
        end else if (bus.rd_req && !w_rd_hit && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_otp_pad_store.sv
// ----------------------------------------------------------------------------
// tb_otp_pad_store
// Self-checking bench for otp_pad_store: directed vector table, hand-written
// multi-cycle sequences (reset/scrub, full/wrap, mid-operation reset, error
// counter saturation) and randomized traffic, all compared each cycle against
// a behavioural model of the pad store kept in this file.
// ----------------------------------------------------------------------------
module tb_otp_pad_store;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [AW:0] live_cnt;
    logic       busy;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    otp_pad_store_if #(.AW(AW), .DW(DW)) bus ();

    otp_pad_store #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .o_live_cnt (live_cnt),
        .o_busy     (busy),
        .o_err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    logic [DW-1:0]    m_pad [DEPTH];
    logic [DEPTH-1:0] m_live;
    int               m_wp;
    int               m_scrubbed;
    logic             m_run;
    logic             m_rv;
    logic [DW-1:0]    m_rd;
    logic             m_re;
    int               m_errs;

    function automatic void model_edge(input logic rst, input logic wv, input logic [DW-1:0] wd,
                                       input logic rq, input logic [AW-1:0] ri);
        logic fire;
        logic hit;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m_pad[i] = '0;
            m_live = '0; m_wp = 0; m_scrubbed = 0; m_run = 1'b0;
            m_rv = 1'b0; m_rd = '0; m_re = 1'b0; m_errs = 0;
            return;
        end
        fire = wv && m_run && !m_live[m_wp];
        hit  = rq && m_run && m_live[ri];
        m_rv = rq;
        if (rq) begin
            if (hit) begin
                m_rd = m_pad[ri]; m_re = 1'b0;
                m_pad[ri] = '0; m_live[ri] = 1'b0;
            end else begin
                m_rd = '0; m_re = 1'b1;
                if (m_errs < 255) m_errs++;
            end
        end
        if (fire) begin
            m_pad[m_wp] = wd; m_live[m_wp] = 1'b1;
            m_wp = (m_wp + 1) % DEPTH;
        end
        if (!m_run) begin
            m_scrubbed++;
            if (m_scrubbed == DEPTH) m_run = 1'b1;
        end
    endfunction

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [7:0] exp_err;
`ifdef OTP_STORE_STATS_EN
        exp_err = 8'(m_errs);
`else
        exp_err = 8'h00;
`endif
        check("busy",     32'(busy),         32'(!m_run));
        check("wr_ready", 32'(bus.wr_ready), 32'(m_run && !m_live[m_wp]));
        check("wr_index", 32'(bus.wr_index), 32'(m_wp));
        check("live_cnt", 32'(live_cnt),     32'($countones(m_live)));
        check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        check("rd_data",  32'(bus.rd_data),  32'(m_rd));
        check("rd_err",   32'(bus.rd_err),   32'(m_re));
        check("err_cnt",  32'(err_cnt),      32'(exp_err));
    endtask

    // One clock: drive inputs, advance model, clock edge, compare #1 later.
    task automatic cycle(input logic rst, input logic wv, input logic [DW-1:0] wd,
                         input logic rq, input logic [AW-1:0] ri);
        rst_n        = rst;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_req   = rq;
        bus.rd_index = ri;
        model_edge(rst, wv, wd, rq, ri);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic reset_and_scrub();
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        idle(DEPTH);
    endtask

    // --------------------------------------------------------- vector table
    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rq;
        logic [AW-1:0] ri;
        logic          e_rv;
        logic [DW-1:0] e_rd;
        logic          e_re;
        logic [AW:0]   e_cnt;
        logic          e_ready;
        logic [AW-1:0] e_idx;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0] exp_err;
        rst_n = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0; bus.rd_index = '0;
        model_edge(1'b0, 1'b0, '0, 1'b0, '0);

        // -------------------------------------------- reset and scrub window
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        check("reset_busy",     32'(busy),         32'd1);
        check("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("reset_live_cnt", 32'(live_cnt),     32'd0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b0, '0, (i == 4), 4'd2);
            check("scrub_busy", 32'(busy), 32'd1);
            if (i == 4) begin
                check("scrub_fetch_valid", 32'(bus.rd_valid), 32'd1);
                check("scrub_fetch_err",   32'(bus.rd_err),   32'd1);
                check("scrub_fetch_data",  32'(bus.rd_data),  32'd0);
            end
        end
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        check("run_busy",     32'(busy),         32'd0);
        check("run_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("run_wr_index", 32'(bus.wr_index), 32'd0);
        check("run_live_cnt", 32'(live_cnt),     32'd0);

        // ------------------------------------------------- directed vectors
        //            wv  wd     rq  ri    rv  rd     re  cnt  rdy idx
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 4'd1};
        vecs[1] = '{1'b1, 8'h3C, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 4'd2};
        vecs[2] = '{1'b1, 8'hFF, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b1, 4'd3};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 4'd1, 1'b1, 8'h3C, 1'b0, 5'd2, 1'b1, 4'd3};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 4'd1, 1'b1, 8'h00, 1'b1, 5'd2, 1'b1, 4'd3};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 4'd3};
        vecs[6] = '{1'b1, 8'h77, 1'b1, 4'd3, 1'b1, 8'h00, 1'b1, 5'd3, 1'b1, 4'd4};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 4'd3, 1'b1, 8'h77, 1'b0, 5'd2, 1'b1, 4'd4};
        vecs[8] = '{1'b1, 8'h55, 1'b1, 4'd2, 1'b1, 8'hFF, 1'b0, 5'd2, 1'b1, 4'd5};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 8'hA5, 1'b0, 5'd1, 1'b1, 4'd5};
        // Fresh store: rd_data/rd_err held from the scrub-time miss above.
        for (int v = 0; v < 10; v++) begin
            cycle(1'b1, vecs[v].wv, vecs[v].wd, vecs[v].rq, vecs[v].ri);
            check($sformatf("vec%0d_rd_valid", v), 32'(bus.rd_valid), 32'(vecs[v].e_rv));
            check($sformatf("vec%0d_rd_data", v),  32'(bus.rd_data),  32'(vecs[v].e_rd));
            check($sformatf("vec%0d_rd_err", v),   32'(bus.rd_err),   32'(vecs[v].e_re));
            check($sformatf("vec%0d_live_cnt", v), 32'(live_cnt),     32'(vecs[v].e_cnt));
            check($sformatf("vec%0d_wr_ready", v), 32'(bus.wr_ready), 32'(vecs[v].e_ready));
            check($sformatf("vec%0d_wr_index", v), 32'(bus.wr_index), 32'(vecs[v].e_idx));
        end

        // ---------------------------------------------------- full and wrap
        reset_and_scrub();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, '0);
        check("full_live_cnt", 32'(live_cnt),     32'd16);
        check("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("full_wr_index", 32'(bus.wr_index), 32'd0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 4'd5);
        check("full_fetch5_data",  32'(bus.rd_data),  32'h15);
        check("full_fetch5_ready", 32'(bus.wr_ready), 32'd0);
        check("full_no_overwrite", 32'(live_cnt),     32'd15);
        // Burn slot 0 while a write is offered: ready only rises afterwards.
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 4'd0);
        check("wrap_fetch0_data", 32'(bus.rd_data),  32'h10);
        check("wrap_ready_after", 32'(bus.wr_ready), 32'd1);
        check("wrap_live_cnt",    32'(live_cnt),     32'd14);
        check("wrap_wr_index",    32'(bus.wr_index), 32'd0);
        cycle(1'b1, 1'b1, 8'h99, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b1, 4'd0);
        check("wrap_slot0_data", 32'(bus.rd_data), 32'h99);
        check("wrap_slot0_err",  32'(bus.rd_err),  32'd0);

        // ------------------------------------------------ mid-op reset + hit
        cycle(1'b0, 1'b0, '0, 1'b1, 4'd1);
        check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("midrst_live_cnt", 32'(live_cnt),     32'd0);
        check("midrst_busy",     32'(busy),         32'd1);
        idle(DEPTH);
        check("midrst_run", 32'(busy), 32'd0);

        // ---------------------------------------- error counter saturation
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, '0, 1'b1, 4'(i));
`ifdef OTP_STORE_STATS_EN
        exp_err = 8'hFF;
`else
        exp_err = 8'h00;
`endif
        check("err_cnt_after_300", 32'(err_cnt), 32'(exp_err));

        // ------------------------------------------------- random traffic
        reset_and_scrub();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 399) != 0),
                  ($urandom_range(0, 1) == 1),
                  8'($urandom),
                  ($urandom_range(0, 4) < 2),
                  4'($urandom_range(0, DEPTH - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
